data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder that serves the load/store requests the memory stage issues (write enable, 16-bit address, 16-bit store data) and returns load data. It replaces the single-cycle main-memory model with a req/ready/response handshake and a programmable number of wait states. A busy output lets hazard control stall the pipeline while an access is in flight. It sits between the memory stage and the backing word array and honours the system halt.

## Interface
Parameters:
- DEPTH, 256: number of 16-bit words; power of two, 2..65536; AW = log2(DEPTH).
- LATENCY, 2: wait-state cycles between acceptance and response; 0..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- halt_sys  in  1  system halt; freezes the block while high.
- req_valid  in  1  request present.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  16 (types_pkg::uword)  word address; only bits [AW-1:0] are used.
- req_wdata  in  16 (types_pkg::uword)  store data.
- req_ready  out  1  block can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse marking completion.
- rsp_rdata  out  16 (types_pkg::uword)  load data, or echoed store data for a store.
- busy  out  1  high whenever the state is not IDLE; drives the pipeline stall.

## Operation
- States: CLEAR, IDLE, WAIT, RESP.
- CLEAR
  - Entered on any cycle with rst high, including mid-access.
  - After rst falls, writes 0 to one word per cycle at addresses 0..DEPTH-1, then moves to IDLE.
  - req_ready is 0 throughout.
- IDLE
  - req_ready = 1.
  - When req_valid & req_ready, the block latches req_we, req_addr[AW-1:0] and req_wdata.
  - Moves to WAIT if LATENCY > 0, otherwise directly to RESP.
- WAIT
  - A counter loads LATENCY-1 and decrements each cycle.
  - At 0 the block moves to RESP.
- RESP
  - rsp_valid = 1 for exactly one cycle.
  - Load: rsp_rdata = mem[latched addr].
  - Store: mem[latched addr] is written on the clock edge leaving RESP, and rsp_rdata = latched wdata.
  - Moves to IDLE next.
- Address handling: upper address bits are ignored, so address DEPTH+k aliases to word k. No error is reported.
- Request inputs are ignored outside IDLE. A requester must hold req_valid and its request fields until it sees req_ready.
- halt_sys high:
  - State, counter, clear pointer and latched request all hold.
  - No memory write occurs.
  - rsp_valid and req_ready are forced to 0; busy keeps reflecting the state.
  - Operation resumes exactly where it stopped once halt_sys falls.
- rst takes priority over halt_sys. Any pending store is discarded on reset.
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, busy = 1, state = CLEAR.
  - Clear pointer = 0, counter = 0.
- rsp_rdata holds its last value outside RESP. It is cleared only by rst.

## Timing
- A request is accepted at edge N (req_valid = 1 while req_ready = 1).
  - busy = 1 from cycle N+1.
  - rsp_valid = 1 in cycle N+LATENCY+1.
  - req_ready = 1 again in cycle N+LATENCY+2.
- With LATENCY = 0, the response comes in the cycle after acceptance, and the minimum request-to-request spacing is 2 cycles.
- Each halt cycle adds exactly one cycle to the in-flight latency.
- Clear takes DEPTH cycles after rst falls. The first request can be accepted in cycle DEPTH+1 after rst deassertion.
- A load that follows a store to the same address returns the stored value; no bypass is needed because the store commits before IDLE.
- Memory reads are synchronous from the latched address. rsp_rdata is registered and valid in the cycle rsp_valid is high.

## Test plan
- Reset and clear:
  - Hold rst 3 cycles, release → busy = 1 and req_ready = 0 for 256 cycles, then req_ready = 1.
  - A load of address 0x00FF returns 0x0000.
- Store then load (LATENCY = 2):
  - Store 0xBEEF to 0x0012 → rsp_valid 3 cycles after acceptance, with rsp_rdata = 0xBEEF.
  - A following load of 0x0012 → 0xBEEF with the same latency.
- Aliasing: store 0x1234 to 0x0105 → a load of 0x0005 returns 0x1234.
- Halt mid-access:
  - Accept a load, raise halt_sys for 4 cycles during WAIT → rsp_valid arrives 4 cycles later than nominal.
  - No rsp_valid or req_ready pulse occurs while halted; the data is correct.
- Reset mid-store: accept a store of 0xAAAA to 0x0020, assert rst in WAIT → after the clear completes, a load of 0x0020 returns 0x0000.
- LATENCY = 0 variant: back-to-back loads held valid → one response every 2 cycles, each arriving 1 cycle after its acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: req/ready handshake, programmable wait states,
// post-reset zero fill of the word array, and a system-halt freeze.
package types_pkg;
  typedef logic [15:0] uword;
endpackage

module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt_sys,
  input  logic            req_valid,
  input  logic            req_we,
  input  types_pkg::uword req_addr,
  input  types_pkg::uword req_wdata,
  output logic            req_ready,
  output logic            rsp_valid,
  output types_pkg::uword rsp_rdata,
  output logic            busy
);
  import types_pkg::*;

  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] clr_ptr;
  logic [3:0]    cnt;
  logic          adv, accept;

  logic          lat_we;
  logic [AW-1:0] lat_addr;
  uword          lat_wdata;

  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_we, wr_en;
  uword          rd_wdata, rdata_nxt, wr_data;

  uword mem [DEPTH];

  // Upper address bits are intentionally dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  assign adv       = !rst && !halt_sys;
  assign req_ready = adv && (state == S_IDLE);
  assign rsp_valid = adv && (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign accept    = req_ready && req_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_ptr == LAST_ADDR) state_nxt = S_IDLE;
      S_IDLE:  if (accept) state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // With zero wait states the response is loaded straight from the request fields.
  assign rd_addr   = (state == S_IDLE) ? req_addr[AW-1:0] : lat_addr;
  assign rd_we     = (state == S_IDLE) ? req_we : lat_we;
  assign rd_wdata  = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign rdata_nxt = rd_we ? rd_wdata : mem[rd_addr];

  assign wr_en   = adv && ((state == S_CLEAR) || ((state == S_RESP) && lat_we));
  assign wr_addr = (state == S_CLEAR) ? clr_ptr : lat_addr;
  assign wr_data = (state == S_CLEAR) ? '0 : lat_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLEAR;
      clr_ptr   <= '0;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
    end else if (!halt_sys) begin
      state <= state_nxt;
      if (state == S_CLEAR) clr_ptr <= clr_ptr + AW'(1);
      if (accept) cnt <= CNT_INIT;
      else if ((state == S_WAIT) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
      if (state_nxt == S_RESP) rsp_rdata <= rdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr[AW-1:0];
      lat_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: clear, store/load, aliasing, halt, reset mid-store,
// and a zero-wait-state instance driven back to back.
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, halt_sys;
  logic        req_valid, req_we, req_ready, rsp_valid, busy;
  logic [15:0] req_addr, req_wdata, rsp_rdata;
  logic        req_valid_z, req_we_z, req_ready_z, rsp_valid_z, busy_z;
  logic [15:0] req_addr_z, req_wdata_z, rsp_rdata_z;

  int n_checks = 0;
  int n_pass   = 0;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  data_mem_responder #(.DEPTH(8), .LATENCY(0)) dut_z (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .req_valid(req_valid_z), .req_we(req_we_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .req_ready(req_ready_z), .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z), .busy(busy_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction on the LATENCY=2 instance; optional halt starting in the first WAIT cycle.
  task automatic xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                      input int halt_len, output logic [15:0] rdata, output int lat);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    tick;
    req_valid = 1'b0;
    lat = 1;
    for (int h = 0; h < halt_len; h++) begin
      halt_sys = 1'b1;
      #1;
      chk("halt_rsp_quiet", rsp_valid, 1'b0);
      chk("halt_rdy_quiet", req_ready, 1'b0);
      chk("halt_busy", busy, 1'b1);
      tick;
      lat++;
    end
    halt_sys = 1'b0;
    #1;
    while (!rsp_valid && lat < 60) begin
      tick;
      lat++;
    end
    rdata = rsp_rdata;
    tick;
    chk("ready_after_rsp", req_ready, 1'b1);
    chk("rsp_one_pulse", rsp_valid, 1'b0);
  endtask

  task automatic wait_clear(input string tag);
    int n;
    logic busy_dropped;
    n = 0;
    busy_dropped = 1'b0;
    while (!req_ready && n < 400) begin
      if (!busy) busy_dropped = 1'b1;
      n++;
      tick;
    end
    chk({tag, "_cycles"}, n, 256);
    chk({tag, "_busy_held"}, busy_dropped, 1'b0);
  endtask

  initial begin
    logic [15:0] rd;
    int lat;
    rst = 1'b1; halt_sys = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0;
    tick; tick; tick;
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0000);
    chk("rst_busy_z", busy_z, 1'b1);

    rst = 1'b0;
    #1;
    wait_clear("clear");

    xact(1'b0, 16'h00FF, 16'h0000, 0, rd, lat);
    chk("clear_load_data", rd, 16'h0000);
    chk("clear_load_lat", lat, 3);

    xact(1'b1, 16'h0012, 16'hBEEF, 0, rd, lat);
    chk("store_echo", rd, 16'hBEEF);
    chk("store_lat", lat, 3);
    chk("rdata_holds_idle", rsp_rdata, 16'hBEEF);

    xact(1'b0, 16'h0012, 16'h0000, 0, rd, lat);
    chk("load_after_store", rd, 16'hBEEF);
    chk("load_lat", lat, 3);

    xact(1'b1, 16'h0105, 16'h1234, 0, rd, lat);
    xact(1'b0, 16'h0005, 16'h0000, 0, rd, lat);
    chk("alias_load", rd, 16'h1234);
    xact(1'b0, 16'h0012, 16'h0000, 0, rd, lat);
    chk("alias_no_clobber", rd, 16'hBEEF);

    xact(1'b0, 16'h0012, 16'h0000, 4, rd, lat);
    chk("halt_load_data", rd, 16'hBEEF);
    chk("halt_load_lat", lat, 7);

    // Zero-wait-state instance: store, then loads held valid on an aliased address.
    req_valid_z = 1'b1; req_we_z = 1'b1; req_addr_z = 16'h0003; req_wdata_z = 16'h1111;
    chk("z_ready_idle", req_ready_z, 1'b1);
    tick;
    req_valid_z = 1'b0;
    chk("z_store_rsp", rsp_valid_z, 1'b1);
    chk("z_store_echo", rsp_rdata_z, 16'h1111);
    tick;
    chk("z_ready_back", req_ready_z, 1'b1);
    req_valid_z = 1'b1; req_we_z = 1'b0; req_addr_z = 16'h000B;
    for (int i = 0; i < 6; i++) begin
      chk("z_b2b_ready", req_ready_z, (i % 2 == 0));
      chk("z_b2b_rsp", rsp_valid_z, (i % 2 == 1));
      if (i % 2 == 1) chk("z_b2b_data", rsp_rdata_z, 16'h1111);
      tick;
    end
    req_valid_z = 1'b0;

    // Reset during an in-flight store must discard it and re-clear the array.
    xact(1'b1, 16'h0020, 16'h5555, 0, rd, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'hAAAA;
    tick;
    req_valid = 1'b0;
    chk("midrst_in_wait", busy, 1'b1);
    rst = 1'b1;
    tick; tick;
    chk("midrst_ready", req_ready, 1'b0);
    chk("midrst_rdata", rsp_rdata, 16'h0000);
    rst = 1'b0;
    #1;
    wait_clear("reclear");
    xact(1'b0, 16'h0020, 16'h0000, 0, rd, lat);
    chk("midrst_load", rd, 16'h0000);
    xact(1'b0, 16'h0012, 16'h0000, 0, rd, lat);
    chk("reclear_load", rd, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
